bitlet_prim_pingpong_buffer_array: RTL and testbench

//  Double-banked (ping-pong) buffer array with valid/ready handshakes on both sides.

---
 rtl/bitlet_prim_pingpong_buffer_array_pkg.sv | 21 ++
 rtl/bitlet_prim_pingpong_buffer_array_bank.sv | 98 +++++++++
 rtl/bitlet_prim_pingpong_buffer_array.sv | 139 +++++++++++++
 tb/tb_bitlet_prim_pingpong_buffer_array.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bitlet_prim_pingpong_buffer_array_pkg.sv
// Package shared by the ping-pong buffer array and its bank sub-module.
// Contents:
//   bank_e       - bank index encoding (two banks, one bit)
//   bank_onehot  - converts a bank index into a 2-bit per-bank select
package bitlet_prim_pingpong_buffer_array_pkg;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  function automatic logic [1:0] bank_onehot(input bank_e b);
    logic [1:0] oh;
    case (b)
      BANK_1:  oh = 2'b10;
      default: oh = 2'b01;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bitlet_prim_pingpong_buffer_array_bank.sv
// One bank of the ping-pong buffer: N slot registers written one at a time,
// a per-slot written mask, a written-slot count, and mask-gated read data.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (clears mask and count only)
//   wr_en_i    write one slot this cycle
//   wr_idx_i   slot index to write
//   wr_data_i  slot data
//   clr_i      empty the bank (batch consumed)
//   rd_data_o  slot g at [g*W +: W]; unwritten slots read as 0
//   mask_o     bit g = slot g written since the last clear
//   cnt_o      number of slots written since the last clear
module bitlet_prim_pingpong_buffer_array_bank #(
  parameter int N = 4,
  parameter int W = 16,
  localparam int PW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_i,
  input  logic [PW-1:0]   wr_idx_i,
  input  logic [W-1:0]    wr_data_i,
  input  logic            clr_i,
  output logic [N*W-1:0]  rd_data_o,
  output logic [N-1:0]    mask_o,
  output logic [CW-1:0]   cnt_o
);

  logic [W-1:0]  data_q [N];
  logic [N-1:0]  mask_q, mask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  wr_sel_s;

  // One-hot slot select decoded from the write index.
  always_comb begin
    wr_sel_s = '0;
    if (wr_en_i) begin
      wr_sel_s[wr_idx_i] = 1'b1;
    end else begin
      wr_sel_s = '0;
    end
  end

  // Slot data storage; deliberately not reset, the mask hides stale contents.
  always_ff @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (wr_sel_s[g]) begin
        data_q[g] <= wr_data_i;
      end
    end
  end

  // Next-state for mask and count. Clear and write never target the same
  // bank in one cycle (a bank is written only while open, cleared only
  // while closed), so clear simply takes priority.
  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      mask_d = '0;
      cnt_d  = '0;
    end else if (wr_en_i) begin
      mask_d = mask_q | wr_sel_s;
      cnt_d  = cnt_q + CW'(1);
    end else begin
      mask_d = mask_q;
      cnt_d  = cnt_q;
    end
  end

  // Mask and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read data with unwritten slots forced to zero.
  always_comb begin
    rd_data_o = '0;
    for (int g = 0; g < N; g++) begin
      if (mask_q[g]) begin
        rd_data_o[g*W +: W] = data_q[g];
      end else begin
        rd_data_o[g*W +: W] = '0;
      end
    end
  end

  assign mask_o = mask_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/bitlet_prim_pingpong_buffer_array.sv
// Double-banked (ping-pong) buffer array. Serial W-bit writes fill the N slots
// of the write bank; a full or flushed bank is closed and handed to the PE as
// one N*W-bit word with a per-slot valid mask, while the other bank fills.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_valid   in_data valid
//   in_ready   write bank can accept a slot
//   in_data    slot data
//   flush      close the partially filled write bank
//   out_valid  read bank holds a closed batch
//   out_ready  PE consumes the batch
//   out_data   slot g at [g*W +: W]; unfilled slots read as 0
//   out_mask   bit g = slot g written in this batch
//   out_cnt    number of slots written in this batch
module bitlet_prim_pingpong_buffer_array
  import bitlet_prim_pingpong_buffer_array_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16,
  localparam int PW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N-1:0]    out_mask,
  output logic [CW-1:0]   out_cnt
);

  bank_e         wr_bank_q, wr_bank_d;
  bank_e         rd_bank_q, rd_bank_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]    full_q, full_d;

  logic          wfire_s, rfire_s, close_s;
  logic [1:0]    wr_en_s, clr_s;

  logic [N*W-1:0] bank_data_s [2];
  logic [N-1:0]   bank_mask_s [2];
  logic [CW-1:0]  bank_cnt_s  [2];

  // Handshakes and bank close decision. A flush with no write closes the
  // bank only if it holds data and is still open; empty batches never form.
  always_comb begin
    wfire_s = in_valid & ~full_q[wr_bank_q];
    rfire_s = out_ready & full_q[rd_bank_q];
    if (wfire_s) begin
      close_s = flush | (wr_ptr_q == PW'(N - 1));
    end else begin
      close_s = flush & (wr_ptr_q != '0) & ~full_q[wr_bank_q];
    end
  end

  // Control next-state. Close and read always address different banks,
  // so both updates to full_d can be applied independently.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    full_d    = full_q;
    if (close_s) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = bank_e'(~wr_bank_q);
      wr_ptr_d          = '0;
    end else if (wfire_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rfire_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = bank_e'(~rd_bank_q);
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q <= BANK_0;
      rd_bank_q <= BANK_0;
      wr_ptr_q  <= '0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      full_q    <= full_d;
    end
  end

  assign wr_en_s = {2{wfire_s}} & bank_onehot(wr_bank_q);
  assign clr_s   = {2{rfire_s}} & bank_onehot(rd_bank_q);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bitlet_prim_pingpong_buffer_array_bank #(
      .N (N),
      .W (W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_en_s[b]),
      .wr_idx_i  (wr_ptr_q),
      .wr_data_i (in_data),
      .clr_i     (clr_s[b]),
      .rd_data_o (bank_data_s[b]),
      .mask_o    (bank_mask_s[b]),
      .cnt_o     (bank_cnt_s[b])
    );
  end

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];

  // Output mux on the read bank.
  always_comb begin
    case (rd_bank_q)
      BANK_1: begin
        out_data = bank_data_s[1];
        out_mask = bank_mask_s[1];
        out_cnt  = bank_cnt_s[1];
      end
      default: begin
        out_data = bank_data_s[0];
        out_mask = bank_mask_s[0];
        out_cnt  = bank_cnt_s[0];
      end
    endcase
  end

endmodule

// File: tb/tb_bitlet_prim_pingpong_buffer_array.sv
module tb_bitlet_prim_pingpong_buffer_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_mask;
  logic [2:0]  out_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bitlet_prim_pingpong_buffer_array #(.N(4), .W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_cnt   (out_cnt)
  );

  // One cycle of stimulus plus the outputs expected right after that edge.
  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        flush;
    logic        out_ready;
    logic        exp_ir;
    logic        exp_ov;
    logic        chk_pay;
    logic [63:0] exp_data;
    logic [3:0]  exp_mask;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic iv, input logic [15:0] d,
                              input logic fl, input logic ordy, input logic eir,
                              input logic eov, input logic cp, input logic [63:0] ed,
                              input logic [3:0] em, input logic [2:0] ec);
    vec_t v;
    v.rst_n = r; v.in_valid = iv; v.in_data = d; v.flush = fl; v.out_ready = ordy;
    v.exp_ir = eir; v.exp_ov = eov; v.chk_pay = cp;
    v.exp_data = ed; v.exp_mask = em; v.exp_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  // Drive one vector, clock it, then compare outputs 1 time unit after the edge.
  task automatic run_vec(input vec_t v, input int row);
    rst_n     = v.rst_n;
    in_valid  = v.in_valid;
    in_data   = v.in_data;
    flush     = v.flush;
    out_ready = v.out_ready;
    @(posedge clk);
    #1;
    chk("in_ready", row, 64'(in_ready), 64'(v.exp_ir));
    chk("out_valid", row, 64'(out_valid), 64'(v.exp_ov));
    if (v.chk_pay) begin
      chk("out_data", row, out_data, v.exp_data);
      chk("out_mask", row, 64'(out_mask), 64'(v.exp_mask));
      chk("out_cnt", row, 64'(out_cnt), 64'(v.exp_cnt));
    end
  endtask

  initial begin
    logic [15:0] a0, a1, a2, a3;
    vec_t        hv;
    logic [63:0] held;

    // T1: reset held while writes are offered.
    add(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 4'h0, 3'd0);
    add(1'b0, 1'b1, 16'h5678, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 4'h0, 3'd0);
    // T2: full batch into bank 0.
    add(1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b1, 16'h0033, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b1, 16'h0044, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0044_0033_0022_0011, 4'hF, 3'd4);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0044_0033_0022_0011, 4'hF, 3'd4);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 4'h0, 3'd0);
    // T3: partial flush in bank 1, then flush at slot 0 produces nothing.
    add(1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_AAAA, 4'h1, 3'd1);
    add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_AAAA, 4'h1, 3'd1);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 4'h0, 3'd0);
    // T4: backpressure, both banks fill, 9th attempt refused.
    add(1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b1, 16'h0103, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b1, 16'h0104, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0104_0103_0102_0101, 4'hF, 3'd4);
    add(1'b1, 1'b1, 16'h0105, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0104_0103_0102_0101, 4'hF, 3'd4);
    add(1'b1, 1'b1, 16'h0106, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0104_0103_0102_0101, 4'hF, 3'd4);
    add(1'b1, 1'b1, 16'h0107, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0104_0103_0102_0101, 4'hF, 3'd4);
    add(1'b1, 1'b1, 16'h0108, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0104_0103_0102_0101, 4'hF, 3'd4);
    add(1'b1, 1'b1, 16'h0109, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0104_0103_0102_0101, 4'hF, 3'd4);
    add(1'b1, 1'b1, 16'h0109, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0108_0107_0106_0105, 4'hF, 3'd4);
    add(1'b1, 1'b1, 16'h0109, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0108_0107_0106_0105, 4'hF, 3'd4);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0109, 4'h1, 3'd1);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 4'h0, 3'd0);
    // T5: overlap, 16 continuous writes with the PE always ready.
    for (int k = 0; k < 16; k++) begin
      a0 = 16'h1000 + 16'(k);
      a1 = a0 - 16'd1; a2 = a0 - 16'd2; a3 = a0 - 16'd3;
      if ((k % 4) == 3)
        add(1'b1, 1'b1, a0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, {a0, a1, a2, a3}, 4'hF, 3'd4);
      else
        add(1'b1, 1'b1, a0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    end
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 4'h0, 3'd0);
    // T6: reset mid-batch discards the partial fill.
    add(1'b1, 1'b1, 16'h2001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b1, 16'h2002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 3'd0);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 4'h0, 3'd0);
    add(1'b1, 1'b1, 16'h3001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_3001, 4'h1, 3'd1);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 4'h0, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Hand-written: batch held stable under backpressure while the other bank fills.
    held = 64'h4004_4003_4002_4001;
    for (int i = 0; i < 4; i++) begin
      hv.rst_n = 1'b1; hv.in_valid = 1'b1; hv.in_data = 16'h4001 + 16'(i);
      hv.flush = 1'b0; hv.out_ready = 1'b0; hv.exp_ir = 1'b1;
      hv.exp_ov = (i == 3); hv.chk_pay = (i == 3);
      hv.exp_data = held; hv.exp_mask = 4'hF; hv.exp_cnt = 3'd4;
      run_vec(hv, 1000 + i);
    end
    for (int i = 0; i < 4; i++) begin
      hv.in_data = 16'h5001 + 16'(i);
      hv.exp_ir = (i != 3); hv.exp_ov = 1'b1; hv.chk_pay = 1'b1;
      hv.exp_data = held;
      run_vec(hv, 1100 + i);
    end
    hv.in_valid = 1'b0; hv.in_data = 16'h0000; hv.out_ready = 1'b1;
    hv.exp_ir = 1'b1; hv.exp_ov = 1'b1;
    hv.exp_data = 64'h5004_5003_5002_5001;
    run_vec(hv, 1200);
    hv.exp_ov = 1'b0; hv.exp_data = 64'h0; hv.exp_mask = 4'h0; hv.exp_cnt = 3'd0;
    run_vec(hv, 1201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
